hub75_capture: RTL and testbench

// - HUB75 receive end: oversamples a HUB75 panel bus (O_CLK/STB/OE/A-D/R1..B2) on the system clock.
// - Deserialises each shifted row into a ping-pong line buffer.
// - Replays each row as bit-plane writes into a framebuffer write port.
// - Used as a loopback panel model for the display driver and as a bus sniffer on hardware.

---
 rtl/hub75_capture.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_hub75_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 receive end: oversamples the panel bus, deserialises each row into a
// ping-pong line buffer and replays it as bit-plane writes to a framebuffer.
module hub75_capture #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_enable,
    input  logic                                   O_CLK,
    input  logic                                   STB,
    input  logic                                   OE,
    input  logic                                   A,
    input  logic                                   B,
    input  logic                                   C,
    input  logic                                   D,
    input  logic                                   R1,
    input  logic                                   G1,
    input  logic                                   B1,
    input  logic                                   R2,
    input  logic                                   G2,
    input  logic                                   B2,
    output logic                                   o_wr_valid,
    input  logic                                   i_wr_ready,
    output logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_wr_addr,
    output logic [$clog2(bpp_p)-1:0]               o_wr_plane,
    output logic [3*segments_p-1:0]                o_wr_data,
    output logic                                   o_frame_start,
    output logic                                   o_err_short,
    output logic                                   o_err_overrun,
    output logic [15:0]                            o_oe_cycles
);
    localparam int aw_lp = $clog2(hpixel_p*vpixel_p);
    localparam int pw_lp = $clog2(bpp_p);
    localparam int iw_lp = $clog2(hpixel_p);
    localparam int cw_lp = iw_lp + 1;
    localparam int dw_lp = 3*segments_p;
    localparam logic [cw_lp-1:0] hp_lp        = cw_lp'(hpixel_p);
    localparam logic [pw_lp-1:0] plane_max_lp = pw_lp'(bpp_p - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;

    logic [12:0]                  sync1_q, sync2_q;
    logic [1:0]                   edge_q;
    logic [dw_lp-1:0]             line_mem [2*hpixel_p];

    logic [cw_lp-1:0]             col_q, col_d;
    logic                         fill_q, fill_d, lost_q, lost_d;
    logic [1:0]                   pend_q, pend_d;
    logic [1:0][hpixel_p-1:0]     mask_q, mask_d;
    logic [1:0][3:0]              tag_row_q, tag_row_d;
    logic [1:0][pw_lp-1:0]        tag_plane_q, tag_plane_d;
    logic [pw_lp-1:0]             plane_q, plane_d;
    logic [3:0]                   last_row_q, last_row_d;
    logic [15:0]                  oe_cnt_q, oe_cnt_d, oe_out_q, oe_out_d;
    logic                         short_q, short_d, ovr_q, ovr_d, fs_q, fs_d;

    state_t                       state_q, state_d;
    logic                         drn_bank_q, drn_bank_d, next_drn_q, next_drn_d;
    logic [cw_lp-1:0]             rd_col_q, rd_col_d;
    logic                         valid_q, valid_d;
    logic [aw_lp-1:0]             addr_q, addr_d;
    logic [pw_lp-1:0]             wplane_q, wplane_d;
    logic [dw_lp-1:0]             data_q, data_d;

    logic                         shift_edge_s, stb_edge_s, oe_low_s, fill_busy_s;
    logic                         shift_take_s, mem_we_s, drn_free_s;
    logic [3:0]                   row_s;
    logic [dw_lp-1:0]             pix_s, rd_data_s;
    logic [cw_lp-1:0]             col_eff_s;
    logic [pw_lp-1:0]             plane_new_s;
    logic [15:0]                  oe_inc_s;

    assign shift_edge_s = i_enable & sync2_q[12] & ~edge_q[1];
    assign stb_edge_s   = i_enable & sync2_q[11] & ~edge_q[0];
    assign oe_low_s     = ~sync2_q[10];
    assign row_s        = sync2_q[9:6];
    assign pix_s        = sync2_q[5:0];
    assign fill_busy_s  = pend_q[fill_q];
    assign shift_take_s = shift_edge_s & (col_q != hp_lp);
    assign mem_we_s     = shift_take_s & ~fill_busy_s;
    // An O_CLK edge coinciding with STB still belongs to the line being latched.
    assign col_eff_s    = shift_take_s ? col_q + cw_lp'(1) : col_q;
    assign plane_new_s  = (row_s != last_row_q) ? '0 :
                          (plane_q == plane_max_lp) ? '0 : plane_q + pw_lp'(1);
    assign oe_inc_s     = (oe_low_s && (oe_cnt_q != 16'hFFFF)) ? oe_cnt_q + 16'd1 : oe_cnt_q;
    // Columns never shifted in read as zero, so short lines drain clean.
    assign rd_data_s    = mask_q[drn_bank_q][rd_col_q[iw_lp-1:0]] ?
                          line_mem[{drn_bank_q, rd_col_q[iw_lp-1:0]}] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= {O_CLK, STB, OE, A, B, C, D, B2, G2, R2, B1, G1, R1};
            sync2_q <= sync1_q;
            edge_q  <= sync2_q[12:11];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            line_mem[{fill_q, col_q[iw_lp-1:0]}] <= pix_s;
        end
    end

    always_comb begin
        col_d       = col_q;
        fill_d      = fill_q;
        lost_d      = lost_q;
        pend_d      = pend_q;
        mask_d      = mask_q;
        tag_row_d   = tag_row_q;
        tag_plane_d = tag_plane_q;
        plane_d     = plane_q;
        last_row_d  = last_row_q;
        oe_cnt_d    = oe_cnt_q;
        oe_out_d    = oe_out_q;
        short_d     = 1'b0;
        ovr_d       = 1'b0;
        fs_d        = 1'b0;
        if (!i_enable) begin
            col_d    = '0;
            fill_d   = 1'b0;
            lost_d   = 1'b0;
            pend_d   = '0;
            mask_d   = '0;
            oe_cnt_d = '0;
        end else begin
            oe_cnt_d = oe_inc_s;
            col_d    = col_eff_s;
            // A line that hits a still-busy fill bank is marked lost, not written.
            if (shift_take_s && fill_busy_s) begin
                lost_d = 1'b1;
            end else if (shift_take_s) begin
                mask_d[fill_q][col_q[iw_lp-1:0]] = 1'b1;
            end else begin
                lost_d = lost_q;
            end
            if (drn_free_s) begin
                pend_d[drn_bank_q] = 1'b0;
                mask_d[drn_bank_q] = '0;
            end else begin
                pend_d = pend_d;
            end
            if (stb_edge_s) begin
                short_d    = (col_eff_s != hp_lp);
                plane_d    = plane_new_s;
                last_row_d = row_s;
                oe_out_d   = oe_inc_s;
                oe_cnt_d   = '0;
                fs_d       = (row_s == 4'd0) && (plane_new_s == '0);
                col_d      = '0;
                lost_d     = 1'b0;
                if (fill_busy_s || lost_q || (shift_take_s && fill_busy_s)) begin
                    ovr_d = 1'b1;
                    if (!fill_busy_s) begin
                        mask_d[fill_q] = '0;
                    end else begin
                        mask_d[fill_q] = mask_d[fill_q];
                    end
                end else begin
                    pend_d[fill_q]      = 1'b1;
                    tag_row_d[fill_q]   = row_s;
                    tag_plane_d[fill_q] = plane_new_s;
                    fill_d              = ~fill_q;
                end
            end else begin
                plane_d = plane_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        drn_bank_d = drn_bank_q;
        next_drn_d = next_drn_q;
        rd_col_d   = rd_col_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wplane_d   = wplane_q;
        data_d     = data_q;
        drn_free_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pend_q[next_drn_q]) begin
                    state_d    = ST_DRAIN;
                    drn_bank_d = next_drn_q;
                    rd_col_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if ((!valid_q || i_wr_ready) && (rd_col_q != hp_lp)) begin
                    valid_d  = 1'b1;
                    addr_d   = aw_lp'(tag_row_q[drn_bank_q]) * aw_lp'(hpixel_p) + aw_lp'(rd_col_q);
                    wplane_d = tag_plane_q[drn_bank_q];
                    data_d   = rd_data_s;
                    rd_col_d = rd_col_q + cw_lp'(1);
                end else if (!valid_q || i_wr_ready) begin
                    valid_d    = 1'b0;
                    drn_free_s = 1'b1;
                    next_drn_d = ~drn_bank_q;
                    state_d    = ST_DONE;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!i_enable) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            rd_col_d   = '0;
            next_drn_d = 1'b0;
            drn_free_s = 1'b0;
        end else begin
            next_drn_d = next_drn_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            fill_q      <= 1'b0;
            lost_q      <= 1'b0;
            pend_q      <= '0;
            mask_q      <= '0;
            tag_row_q   <= '0;
            tag_plane_q <= '0;
            plane_q     <= '0;
            last_row_q  <= 4'hF;
            oe_cnt_q    <= '0;
            oe_out_q    <= '0;
            short_q     <= 1'b0;
            ovr_q       <= 1'b0;
            fs_q        <= 1'b0;
            state_q     <= ST_IDLE;
            drn_bank_q  <= 1'b0;
            next_drn_q  <= 1'b0;
            rd_col_q    <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wplane_q    <= '0;
            data_q      <= '0;
        end else begin
            col_q       <= col_d;
            fill_q      <= fill_d;
            lost_q      <= lost_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            tag_row_q   <= tag_row_d;
            tag_plane_q <= tag_plane_d;
            plane_q     <= plane_d;
            last_row_q  <= last_row_d;
            oe_cnt_q    <= oe_cnt_d;
            oe_out_q    <= oe_out_d;
            short_q     <= short_d;
            ovr_q       <= ovr_d;
            fs_q        <= fs_d;
            state_q     <= state_d;
            drn_bank_q  <= drn_bank_d;
            next_drn_q  <= next_drn_d;
            rd_col_q    <= rd_col_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wplane_q    <= wplane_d;
            data_q      <= data_d;
        end
    end

    assign o_wr_valid    = valid_q;
    assign o_wr_addr     = addr_q;
    assign o_wr_plane    = wplane_q;
    assign o_wr_data     = data_q;
    assign o_frame_start = fs_q;
    assign o_err_short   = short_q;
    assign o_err_overrun = ovr_q;
    assign o_oe_cycles   = oe_out_q;
endmodule

// File: tb/tb_hub75_capture.sv
// Directed/random bench for hub75_capture: drives the HUB75 bus and scores
// framebuffer writes against a line-level reference model.
module tb_hub75_capture;
    logic        clk = 1'b0, rst = 1'b1, i_enable = 1'b0;
    logic        O_CLK = 1'b0, STB = 1'b0, OE = 1'b1;
    logic        A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic        R1 = 1'b0, G1 = 1'b0, B1 = 1'b0, R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
    logic        i_wr_ready = 1'b0;
    logic        o_wr_valid, o_frame_start, o_err_short, o_err_overrun;
    logic [11:0] o_wr_addr;
    logic [2:0]  o_wr_plane;
    logic [5:0]  o_wr_data;
    logic [15:0] o_oe_cycles;

    typedef struct packed {
        logic [11:0] addr;
        logic [2:0]  plane;
        logic [5:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur_w, prev_w, exp_w;
    logic        prev_stall = 1'b0;
    logic [5:0]  pix [64];
    int          checks = 0, errors = 0;
    int          fs_cnt = 0, sh_cnt = 0, ov_cnt = 0;
    int          exp_fs = 0, exp_sh = 0, exp_ov = 0;
    int          ready_mode = 2;
    int          m_last_row = 15, m_plane = 0;

    hub75_capture dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .O_CLK(O_CLK), .STB(STB), .OE(OE),
        .A(A), .B(B), .C(C), .D(D),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .o_wr_addr(o_wr_addr), .o_wr_plane(o_wr_plane), .o_wr_data(o_wr_data),
        .o_frame_start(o_frame_start), .o_err_short(o_err_short),
        .o_err_overrun(o_err_overrun), .o_oe_cycles(o_oe_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: plane sequencing, at most two buffered lines, one write per column.
    task automatic model_latch(input int ncols, input int row);
        wr_t w;
        if (row != m_last_row) m_plane = 0;
        else m_plane = (m_plane + 1) % 8;
        m_last_row = row;
        if (ncols != 64) exp_sh++;
        if (row == 0 && m_plane == 0) exp_fs++;
        if (exp_q.size() > 64) begin
            exp_ov++;
        end else begin
            for (int c = 0; c < 64; c++) begin
                w.addr  = 12'(row * 64 + c);
                w.plane = 3'(m_plane);
                w.data  = (c < ncols) ? pix[c] : 6'd0;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic send_line(input int ncols, input logic [3:0] row);
        for (int c = 0; c < ncols; c++) begin
            {B2, G2, R2, B1, G1, R1} = pix[c];
            tick(3);
            O_CLK = 1'b1;
            tick(3);
            O_CLK = 1'b0;
        end
        {A, B, C, D} = row;
        tick(3);
        model_latch(ncols, int'(row));
        STB = 1'b1;
        tick(3);
        STB = 1'b0;
        tick(5);
    endtask

    task automatic rand_pix();
        for (int c = 0; c < 64; c++) pix[c] = 6'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_wr_valid) && n < 5000) begin
            tick(1);
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_wr_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 2);
        end
    end

    // Write scoreboard, handshake-stability check and pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            cur_w = {o_wr_addr, o_wr_plane, o_wr_data};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", o_wr_valid, 1);
                    chk("hold_word", cur_w, prev_w);
                end
                if (o_wr_valid && i_wr_ready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL spurious_write: observed addr %0d expected no write", o_wr_addr);
                    end
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        chk("write", cur_w, exp_w);
                    end
                end
                if (o_frame_start) fs_cnt++;
                if (o_err_short) sh_cnt++;
                if (o_err_overrun) ov_cnt++;
                prev_stall = o_wr_valid && !i_wr_ready;
                prev_w = cur_w;
            end
        end
    end

    initial begin
        int n;
        logic [6:0] cv;
        tick(4);
        chk("rst_valid", o_wr_valid, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_plane", o_wr_plane, 0);
        chk("rst_data", o_wr_data, 0);
        chk("rst_pulses", {o_frame_start, o_err_short, o_err_overrun}, 0);
        chk("rst_oe", o_oe_cycles, 0);
        rst = 1'b0;
        tick(2);
        i_enable = 1'b1;
        ready_mode = 1;
        tick(4);

        for (int c = 0; c < 64; c++) begin
            cv = 7'(c);
            pix[c] = {1'b0, cv[1], 3'b000, cv[0]};
        end
        send_line(64, 4'd5);
        wait_drain();
        for (int k = 0; k < 7; k++) begin
            rand_pix();
            send_line(64, 4'd5);
            wait_drain();
        end
        rand_pix();
        send_line(64, 4'd6);
        wait_drain();
        chk("short_none", sh_cnt, exp_sh);

        rand_pix();
        send_line(63, 4'd6);
        wait_drain();
        chk("short_cnt", sh_cnt, exp_sh);

        OE = 1'b0;
        tick(37);
        OE = 1'b1;
        tick(4);
        rand_pix();
        send_line(64, 4'd0);
        chk("oe_cycles", o_oe_cycles, 37);
        wait_drain();
        chk("frame_start_cnt", fs_cnt, exp_fs);

        ready_mode = 0;
        for (int k = 1; k <= 3; k++) begin
            rand_pix();
            send_line(64, 4'(k));
        end
        chk("overrun_cnt", ov_cnt, exp_ov);
        chk("stall_valid", o_wr_valid, 1);
        chk("stall_addr", o_wr_addr, 64);
        ready_mode = 1;
        wait_drain();

        ready_mode = 0;
        rand_pix();
        send_line(64, 4'd7);
        n = 0;
        while (!o_wr_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk("valid_before_rst", o_wr_valid, 1);
        #1 rst = 1'b1;
        #1 chk("rst_mid_drain_valid", o_wr_valid, 0);
        tick(3);
        exp_q.delete();
        m_last_row = 15;
        m_plane = 0;
        rst = 1'b0;
        ready_mode = 1;
        tick(20);
        chk("post_rst_valid", o_wr_valid, 0);

        rand_pix();
        send_line(64, 4'd9);
        wait_drain();
        chk("final_fs", fs_cnt, exp_fs);
        chk("final_short", sh_cnt, exp_sh);
        chk("final_overrun", ov_cnt, exp_ov);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
